// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared encodings and helpers for the memory request scheduler
package mem_sched_pkg;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_STORE = 2'b10
    } cmd_kind_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DROP  = 2'b11
    } state_e;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] ST_BYTE = 2'd0;
    localparam logic [1:0] ST_HALF = 2'd1;
    localparam logic [1:0] ST_WORD = 2'd2;

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFC0;
    localparam logic [31:0] IO_MASK   = 32'h0003_0000;

    // I/O region is any address with bits [17:16] both set.
    function automatic logic is_io_addr(input logic [31:0] addr);
        return (addr & IO_MASK) == IO_MASK;
    endfunction

endpackage

// File: rtl/mem_sched_sq.sv
// rtl/mem_sched_sq.sv - circular FIFO buffering committed stores
module mem_sched_sq
    import mem_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy_i,
    input  logic                          enq_i,
    input  logic [31:0]                   enq_addr_i,
    input  logic [31:0]                   enq_data_i,
    input  logic [1:0]                    enq_size_i,
    input  logic                          deq_i,
    output logic [31:0]                   head_addr_o,
    output logic [31:0]                   head_data_o,
    output logic [1:0]                    head_size_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          st_ready_o,
    output logic                          sq_empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [1:0]    size_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          st_ready_q, sq_empty_q;
    logic          do_enq, do_deq;

    assign do_enq = rdy_i && enq_i && st_ready_q;
    assign do_deq = rdy_i && deq_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_enq && !do_deq) begin
            count_d = count_q + CW'(1);
        end else if (!do_enq && do_deq) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            st_ready_q <= 1'b1;
            sq_empty_q <= 1'b1;
        end else begin
            if (do_enq) begin
                addr_q[wr_q] <= enq_addr_i;
                data_q[wr_q] <= enq_data_i;
                size_q[wr_q] <= enq_size_i;
                wr_q         <= wr_q + AW'(1);
            end
            if (do_deq) begin
                rd_q <= rd_q + AW'(1);
            end
            count_q    <= count_d;
            st_ready_q <= count_d < FULL;
            sq_empty_q <= count_d == '0;
        end
    end

    assign head_addr_o = addr_q[rd_q];
    assign head_data_o = data_q[rd_q];
    assign head_size_o = size_q[rd_q];
    assign count_o     = count_q;
    assign st_ready_o  = st_ready_q;
    assign sq_empty_o  = sq_empty_q;

endmodule

// File: rtl/mem_sched.sv
// rtl/mem_sched.sv - arbitrates fetch/load/store requests onto one sequencer command channel
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter int SQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_size,
    output logic        ld_done,
    output logic [31:0] ld_data,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        sq_empty,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_kind,
    output logic [31:0] cmd_addr,
    output logic [31:0] cmd_data,
    output logic [2:0]  cmd_size,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data
);

    localparam int CW = $clog2(SQ_DEPTH + 1);
    localparam logic [CW-1:0] SQ_FULL = CW'(SQ_DEPTH);

    state_e      state_q;
    cmd_kind_e   kind_q, pick_kind;
    logic        cmd_valid_q, if_done_q, ld_done_q, rr_q;
    logic [31:0] addr_q, data_q, ld_data_q, pick_addr, pick_data;
    logic [2:0]  size_q, pick_size;

    logic [31:0]   head_addr, head_data;
    logic [1:0]    head_size;
    logic [CW-1:0] sq_count;
    logic          sq_deq, st_elig, ld_elig, data_elig, grant, cancellable;

    assign sq_deq = (state_q == S_ISSUE) && cmd_ready && (kind_q == KIND_STORE);

    mem_sched_sq #(.DEPTH(SQ_DEPTH)) u_sq (
        .clk         (clk),
        .rst         (rst),
        .rdy_i       (rdy),
        .enq_i       (st_valid),
        .enq_addr_i  (st_addr),
        .enq_data_i  (st_data),
        .enq_size_i  (st_size),
        .deq_i       (sq_deq),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .head_size_o (head_size),
        .count_o     (sq_count),
        .st_ready_o  (st_ready),
        .sq_empty_o  (sq_empty)
    );

    // I/O stores wait while the I/O buffer is full; loads never pass a queued store.
    assign st_elig     = (sq_count != '0) && (!is_io_addr(head_addr) || !io_buffer_full);
    assign ld_elig     = ld_req && sq_empty;
    assign data_elig   = st_elig || ld_elig;
    assign grant       = !rollback && (if_req || data_elig);
    assign cancellable = kind_q != KIND_STORE;

    always_comb begin
        pick_kind = KIND_FETCH;
        pick_addr = if_addr & LINE_MASK;
        pick_data = '0;
        pick_size = '0;
        if ((sq_count == SQ_FULL && st_elig) ||
            (!(if_req && (!data_elig || !rr_q)) && st_elig)) begin
            pick_kind = KIND_STORE;
            pick_addr = head_addr;
            pick_data = head_data;
            pick_size = {1'b0, head_size};
        end else if (!(if_req && (!data_elig || !rr_q))) begin
            pick_kind = KIND_LOAD;
            pick_addr = ld_addr;
            pick_size = ld_size;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            kind_q      <= KIND_FETCH;
            addr_q      <= '0;
            data_q      <= '0;
            size_q      <= '0;
            cmd_valid_q <= 1'b0;
            if_done_q   <= 1'b0;
            ld_done_q   <= 1'b0;
            ld_data_q   <= '0;
            rr_q        <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            ld_done_q <= 1'b0;
            if (rdy) begin
                case (state_q)
                    S_IDLE: begin
                        if (grant) begin
                            kind_q      <= pick_kind;
                            addr_q      <= pick_addr;
                            data_q      <= pick_data;
                            size_q      <= pick_size;
                            cmd_valid_q <= 1'b1;
                            rr_q        <= ~rr_q;
                            state_q     <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (cmd_ready) begin
                            cmd_valid_q <= 1'b0;
                            state_q     <= (rollback && cancellable) ? S_DROP : S_WAIT;
                        end else if (rollback && cancellable) begin
                            cmd_valid_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                    S_WAIT: begin
                        if (rollback && cancellable) begin
                            state_q <= rsp_valid ? S_IDLE : S_DROP;
                        end else if (rsp_valid) begin
                            if_done_q <= kind_q == KIND_FETCH;
                            ld_done_q <= kind_q == KIND_LOAD;
                            if (kind_q == KIND_LOAD) begin
                                ld_data_q <= rsp_data;
                            end
                            state_q <= S_IDLE;
                        end
                    end
                    S_DROP: begin
                        if (rsp_valid) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_kind  = kind_q;
    assign cmd_addr  = addr_q;
    assign cmd_data  = data_q;
    assign cmd_size  = size_q;
    assign if_done   = if_done_q;
    assign ld_done   = ld_done_q;
    assign ld_data   = ld_data_q;

endmodule

// File: tb/tb_mem_sched.sv
// tb/tb_mem_sched.sv - directed scoreboard bench for mem_sched
module tb_mem_sched;
    import mem_sched_pkg::*;

    logic        clk, rst, rdy, rollback, io_buffer_full;
    logic        if_req, if_done, ld_req, ld_done, st_valid, st_ready, sq_empty;
    logic        cmd_valid, cmd_ready, rsp_valid;
    logic [31:0] if_addr, ld_addr, ld_data, st_addr, st_data;
    logic [31:0] cmd_addr, cmd_data, rsp_data;
    logic [2:0]  ld_size, cmd_size;
    logic [1:0]  st_size, cmd_kind;

    mem_sched #(.SQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
        .ld_done(ld_done), .ld_data(ld_data),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size), .sq_empty(sq_empty),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
    } cmd_t;

    typedef struct {
        logic        if_p;
        logic        ld_p;
        logic [31:0] ldd;
    } done_t;

    cmd_t        exp_cmd[$];
    done_t       exp_done[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_ld = 32'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [1:0] k, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] s);
        cmd_t c;
        c.kind = k; c.addr = a; c.data = d; c.size = s;
        exp_cmd.push_back(c);
    endtask

    task automatic push_done(input logic ip, input logic lp, input logic [31:0] v);
        done_t e;
        e.if_p = ip; e.ld_p = lp; e.ldd = v;
        exp_done.push_back(e);
    endtask

    task automatic accept_cmd(input string tag);
        int   n;
        cmd_t c;
        n = 0;
        while (!cmd_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, " cmd_valid"}, 32'(cmd_valid), 32'd1);
        chk({tag, " sb_nonempty"}, 32'(exp_cmd.size() > 0), 32'd1);
        if (exp_cmd.size() > 0) begin
            c = exp_cmd.pop_front();
            chk({tag, " kind"}, 32'(cmd_kind), 32'(c.kind));
            chk({tag, " addr"}, cmd_addr, c.addr);
            chk({tag, " data"}, cmd_data, c.data);
            chk({tag, " size"}, 32'(cmd_size), 32'(c.size));
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        chk({tag, " cmd_valid_drop"}, 32'(cmd_valid), 32'd0);
    endtask

    task automatic respond(input string tag, input logic [31:0] d, input int gap);
        done_t e;
        repeat (gap) step();
        rsp_valid = 1'b1;
        rsp_data  = d;
        step();
        rsp_valid = 1'b0;
        chk({tag, " sb_done_nonempty"}, 32'(exp_done.size() > 0), 32'd1);
        if (exp_done.size() > 0) begin
            e = exp_done.pop_front();
            chk({tag, " if_done"}, 32'(if_done), 32'(e.if_p));
            chk({tag, " ld_done"}, 32'(ld_done), 32'(e.ld_p));
            chk({tag, " ld_data"}, ld_data, e.ldd);
            if (e.if_p) if_req = 1'b0;
            if (e.ld_p) ld_req = 1'b0;
        end
        step();
        chk({tag, " done_once"}, 32'(if_done | ld_done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; ld_req = 1'b0; ld_addr = '0; ld_size = '0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        repeat (3) step();
        chk("rst cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst cmd_kind", 32'(cmd_kind), 32'd0);
        chk("rst cmd_addr", cmd_addr, 32'd0);
        chk("rst cmd_data", cmd_data, 32'd0);
        chk("rst cmd_size", 32'(cmd_size), 32'd0);
        chk("rst dones", 32'({if_done, ld_done}), 32'd0);
        chk("rst ld_data", ld_data, 32'd0);
        chk("rst st_ready", 32'(st_ready), 32'd1);
        chk("rst sq_empty", 32'(sq_empty), 32'd1);
        rst = 1'b0;
        step();

        // Fill the store queue while the sequencer stalls.
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h1000 + 32'(i * 4);
            st_data  = 32'hA0 + 32'(i);
            st_size  = 2'(i % 3);
            push_cmd(KIND_STORE, st_addr, st_data, {1'b0, st_size});
            push_done(1'b0, 1'b0, last_ld);
            step();
        end
        chk("sq full st_ready", 32'(st_ready), 32'd0);
        st_addr = 32'h1FF0;
        step();
        st_valid = 1'b0;
        chk("sq 5th st_ready", 32'(st_ready), 32'd0);
        repeat (2) step();
        chk("stall cmd_kind", 32'(cmd_kind), 32'(KIND_STORE));
        chk("stall cmd_addr", cmd_addr, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            accept_cmd("store_drain");
            respond("store_drain", 32'h0, 1);
        end
        chk("drain sq_empty", 32'(sq_empty), 32'd1);
        chk("drain st_ready", 32'(st_ready), 32'd1);

        // Fetch and load together: fetch first, load second.
        if_req = 1'b1; if_addr = 32'h1234_5678;
        ld_req = 1'b1; ld_addr = 32'h2000; ld_size = LD_LW;
        push_cmd(KIND_FETCH, 32'h1234_5640, 32'h0, 3'b000);
        push_cmd(KIND_LOAD, 32'h2000, 32'h0, LD_LW);
        push_done(1'b1, 1'b0, last_ld);
        push_done(1'b0, 1'b1, 32'h1122_3344);
        last_ld = 32'h1122_3344;
        cmd_ready = 1'b1;
        accept_cmd("rr_fetch");
        respond("rr_fetch", 32'h0, 2);
        accept_cmd("rr_load");
        respond("rr_load", 32'h1122_3344, 2);

        // I/O store held while the I/O buffer is full.
        io_buffer_full = 1'b1;
        st_valid = 1'b1; st_addr = 32'h0003_0000; st_data = 32'h55; st_size = ST_WORD;
        if_req = 1'b1; if_addr = 32'hABCD_00A5;
        push_cmd(KIND_FETCH, 32'hABCD_0080, 32'h0, 3'b000);
        push_cmd(KIND_STORE, 32'h0003_0000, 32'h55, {1'b0, ST_WORD});
        push_done(1'b1, 1'b0, last_ld);
        push_done(1'b0, 1'b0, last_ld);
        step();
        st_valid = 1'b0;
        accept_cmd("io_fetch");
        respond("io_fetch", 32'h0, 1);
        repeat (3) step();
        chk("io held cmd_valid", 32'(cmd_valid), 32'd0);
        chk("io held sq_empty", 32'(sq_empty), 32'd0);
        io_buffer_full = 1'b0;
        accept_cmd("io_store");
        respond("io_store", 32'h0, 1);

        // Load killed by rollback while waiting for its response.
        ld_req = 1'b1; ld_addr = 32'h3000; ld_size = LD_LBU;
        push_cmd(KIND_LOAD, 32'h3000, 32'h0, LD_LBU);
        accept_cmd("rb_load");
        ld_req = 1'b0;
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        step();
        rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        step();
        rsp_valid = 1'b0;
        chk("rb ld_done", 32'(ld_done), 32'd0);
        chk("rb ld_data", ld_data, last_ld);
        step();
        chk("rb ld_done late", 32'(ld_done), 32'd0);

        // Load waits behind two queued stores.
        st_valid = 1'b1; st_addr = 32'h4000; st_data = 32'h77; st_size = ST_BYTE;
        push_cmd(KIND_STORE, 32'h4000, 32'h77, {1'b0, ST_BYTE});
        push_done(1'b0, 1'b0, last_ld);
        step();
        st_addr = 32'h4004; st_data = 32'h88; st_size = ST_HALF;
        push_cmd(KIND_STORE, 32'h4004, 32'h88, {1'b0, ST_HALF});
        push_done(1'b0, 1'b0, last_ld);
        step();
        st_valid = 1'b0;
        ld_req = 1'b1; ld_addr = 32'h4000; ld_size = LD_LW;
        push_cmd(KIND_LOAD, 32'h4000, 32'h0, LD_LW);
        push_done(1'b0, 1'b1, 32'hCAFE_F00D);
        last_ld = 32'hCAFE_F00D;
        accept_cmd("order_st0");
        respond("order_st0", 32'h0, 2);
        accept_cmd("order_st1");
        respond("order_st1", 32'h0, 2);
        accept_cmd("order_ld");
        respond("order_ld", 32'hCAFE_F00D, 1);

        // rdy low mid-WAIT freezes everything.
        if_req = 1'b1; if_addr = 32'h0000_0100;
        push_cmd(KIND_FETCH, 32'h0000_0100, 32'h0, 3'b000);
        push_done(1'b1, 1'b0, last_ld);
        accept_cmd("rdy_fetch");
        rdy = 1'b0;
        st_valid = 1'b1; st_addr = 32'h5000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rdy frozen cmd_valid", 32'(cmd_valid), 32'd0);
            chk("rdy frozen if_done", 32'(if_done), 32'd0);
            chk("rdy frozen sq_empty", 32'(sq_empty), 32'd1);
        end
        st_valid = 1'b0;
        rdy = 1'b1;
        respond("rdy_resume", 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_sched.md
# mem_sched

Request scheduler in front of the byte-serial RAM sequencer. It arbitrates between instruction-line refills, speculative LSB loads and committed stores. Committed stores are buffered in a 4-entry FIFO. The block issues one transaction descriptor at a time to the sequencer, discards results of loads or fetches killed by rollback, and holds I/O stores while the I/O buffer is full.

## Interface
- Parameters:
- SQ_DEPTH, 4, store-queue entries (power of two, ≥2)
- Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rdy  in  1  global enable; when low all state holds, registered outputs keep value
- rollback  in  1  ROB flush; cancels speculative work
- io_buffer_full  in  1  I/O write buffer full
- if_req  in  1  ifetch line-refill request (level, held until if_done)
- if_addr  in  32  line address; bits [5:0] ignored
- if_done  out  1  one-cycle pulse: line delivered
- ld_req  in  1  load request (level)
- ld_addr  in  32  byte address
- ld_size  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- ld_done  out  1  one-cycle pulse with ld_data
- ld_data  out  32  extended load result
- st_valid  in  1  committed-store enqueue
- st_ready  out  1  store queue not full
- st_addr / st_data / st_size  in  32/32/2  store descriptor (size 0 byte, 1 half, 2 word)
- sq_empty  out  1  store queue empty
- cmd_valid  out  1  descriptor to sequencer
- cmd_ready  in  1  sequencer accepts
- cmd_kind  out  2  00 line fetch, 01 load, 10 store
- cmd_addr / cmd_data / cmd_size  out  32/32/3  descriptor payload
- rsp_valid  in  1  sequencer completion pulse
- rsp_data  in  32  load data (sequencer performs extension)

## Operation
- Store queue: circular FIFO; wr/rd pointers plus count (0..SQ_DEPTH). Enqueue when st_valid && st_ready. st_ready = count < SQ_DEPTH. Simultaneous enqueue and dequeue keep count unchanged. rollback never touches the queue.
- Eligibility:
  - Store eligible if queue non-empty, and either head addr[17:16] != 2'b11 or !io_buffer_full.
  - Load eligible if ld_req and sq_empty. Loads never bypass stores.
  - Fetch eligible if if_req.
- Arbitration:
  - A store wins unconditionally when count == SQ_DEPTH.
  - Otherwise, round-robin between fetch and data (data = store if eligible, else load). A 1-bit pointer toggles on every grant.
  - Reset pointer favours fetch.
- FSM:
  - IDLE: choose a winner and register the descriptor; cmd_valid = 1; go to ISSUE. If rollback is high, no grant is made that cycle.
  - ISSUE: hold the descriptor until cmd_ready. Then cmd_valid = 0, go to WAIT. A store is dequeued at acceptance.
  - WAIT: on rsp_valid, pulse the matching done and return to IDLE.
  - DROP: on rsp_valid, return to IDLE with no done pulse.
- Rollback:
  - In ISSUE with a load or fetch: cmd_valid drops next cycle, go to IDLE. The descriptor is withdrawn; it was never accepted.
  - In WAIT with a load or fetch: go to DROP.
  - A store in ISSUE/WAIT is unaffected.
  - Rollback coincident with rsp_valid in WAIT: completion is discarded, go to IDLE.
- ld_data is captured from rsp_data on the completing cycle.

## Timing
- Reset values: cmd_valid 0, cmd_kind 00, cmd_addr/data/size 0, if_done 0, ld_done 0, ld_data 0, st_ready 1, sq_empty 1, state IDLE, count 0, pointers 0.
- Request seen in IDLE at cycle t → cmd_valid at t+1.
- rsp_valid at cycle u → if_done/ld_done at u+1 (registered one-cycle pulse).
- Minimum turnaround: IDLE→ISSUE→WAIT→IDLE, giving 3 cycles of scheduler overhead per transaction plus sequencer time.
- st_ready and sq_empty are registered, reflecting count after the current cycle's updates.
- The descriptor must not change while cmd_valid && !cmd_ready.
- rdy low freezes the FSM, the queue and the arbiter pointer. Done pulses are not re-emitted.

## Structure
- Shared package: cmd_kind encodings, load/store size encodings, the I/O-region predicate (addr[17:16]==2'b11), and state encodings.
- One sub-module, mem_sched_sq: the parameterised store FIFO (enq/deq, count, head outputs).
- The arbiter and FSM live in the top.

## Test plan
- Reset, then enqueue 4 stores with cmd_ready held 0 → st_ready 0 after the 4th. The 5th st_valid is not accepted; the 1st store descriptor is presented on cmd with kind 10.
- if_req and ld_req both high, sq_empty, cmd_ready=1, rsp after 2 cycles → fetch granted first, load second. Each done pulses exactly once, one cycle after rsp_valid.
- Store to 0x00030000 queued with io_buffer_full=1, and if_req high → fetch issued and store held. Deassert full → store issues with addr 0x00030000.
- Load in WAIT, rollback pulse, then rsp_valid with 0xDEADBEEF → no ld_done, ld_data unchanged, FSM back to IDLE.
- ld_req with 2 stores queued → load not issued until both stores are accepted and completed. Subsequent ld_data equals the value the sequencer returns.
- rdy=0 for 5 cycles mid-WAIT with rsp_valid held 0 → no state change. Resume with rsp_valid → single done pulse.
